set_seq_driver: RTL and testbench

Synthesizable job sequencer for the SET candidate-count engine: it reads stimulus entries (central, radius, expected candidate) from a synchronous pattern ROM, issues each as a single-cycle `en` job, waits for `valid`, and compares `candidate` against the expected value. It replaces the simulation-only stimulus loop on silicon and FPGA builds, so the SET engine can run a built-in self-test. It sits between the pattern ROM and the SET instance and reports pass/fail status to the host.

---
 rtl/set_seq_driver.sv | 143 ++++++++++++++
 tb/tb_set_seq_driver.sv | 363 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/set_seq_driver.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : set_seq_driver
// Description : ROM-driven job sequencer and result checker for the SET
//               candidate-count engine (built-in self-test).
// Revision    : 1.0 - initial release
// ============================================================================
module set_seq_driver #(
  parameter int N_PAT   = 64,
  parameter int AW      = 6,
  parameter int MAX_ERR = 10,
  parameter int TIMEOUT = 1024
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  output logic [AW-1:0] pat_addr,
  input  logic [7:0]    pat_central,
  input  logic [3:0]    pat_radius,
  input  logic [7:0]    pat_expected,
  output logic          en,
  output logic [7:0]    central,
  output logic [3:0]    radius,
  input  logic          busy,
  input  logic          valid,
  input  logic [7:0]    candidate,
  output logic          running,
  output logic          done,
  output logic          timeout,
  output logic [6:0]    err_cnt,
  output logic [AW-1:0] pat_idx
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_FETCH     = 3'd1,
    S_LOAD      = 3'd2,
    S_WAIT_IDLE = 3'd3,
    S_ISSUE     = 3'd4,
    S_WAIT_RSP  = 3'd5,
    S_CHECK     = 3'd6,
    S_DONE      = 3'd7
  } state_t;

  localparam logic [AW-1:0] c_LAST    = AW'(N_PAT - 1);
  localparam logic [6:0]    c_MAX_ERR = 7'(MAX_ERR);
  // The counter holds the count before this cycle's increment, so the
  // expiry cycle is the one whose increment would reach TIMEOUT-1.
  localparam logic [15:0]   c_WD_LAST = 16'(TIMEOUT - 2);

  state_t      r_state;
  logic [7:0]  r_lat_c;
  logic [3:0]  r_lat_r;
  logic [7:0]  r_lat_e;
  logic [7:0]  r_cand;
  logic [15:0] r_wd;
  logic [6:0]  w_err_next;

  assign w_err_next = err_cnt + {6'd0, (r_cand != r_lat_e)};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= S_IDLE;
      r_lat_c  <= '0;
      r_lat_r  <= '0;
      r_lat_e  <= '0;
      r_cand   <= '0;
      r_wd     <= '0;
      pat_addr <= '0;
      en       <= 1'b0;
      central  <= '0;
      radius   <= '0;
      running  <= 1'b0;
      done     <= 1'b0;
      timeout  <= 1'b0;
      err_cnt  <= '0;
      pat_idx  <= '0;
    end else begin
      en <= 1'b0;
      case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            r_state  <= S_FETCH;
            pat_addr <= '0;
            pat_idx  <= '0;
            err_cnt  <= '0;
            timeout  <= 1'b0;
            running  <= 1'b1;
            done     <= 1'b0;
          end
        end
        S_FETCH: r_state <= S_LOAD;
        S_LOAD: begin
          r_lat_c <= pat_central;
          r_lat_r <= pat_radius;
          r_lat_e <= pat_expected;
          r_state <= S_WAIT_IDLE;
        end
        S_WAIT_IDLE: begin
          if (!busy) begin
            en      <= 1'b1;
            central <= r_lat_c;
            radius  <= r_lat_r;
            r_state <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          r_wd    <= '0;
          r_state <= S_WAIT_RSP;
        end
        S_WAIT_RSP: begin
          if (valid) begin
            r_cand  <= candidate;
            r_state <= S_CHECK;
          end else if (r_wd == c_WD_LAST) begin
            timeout <= 1'b1;
            running <= 1'b0;
            done    <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_wd <= r_wd + 16'd1;
          end
        end
        S_CHECK: begin
          err_cnt <= w_err_next;
          if (w_err_next == c_MAX_ERR || pat_idx == c_LAST) begin
            running <= 1'b0;
            done    <= 1'b1;
            r_state <= S_DONE;
          end else begin
            pat_idx  <= pat_idx + 1'b1;
            pat_addr <= pat_addr + 1'b1;
            r_state  <= S_FETCH;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_set_seq_driver.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_set_seq_driver
// Description : Scoreboard bench for set_seq_driver with behavioural ROM/SET.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_set_seq_driver;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b0;
  logic start_a = 1'b0, start_b = 1'b0;
  logic busy_a = 1'b0, spur_a = 1'b0;

  logic [1:0] addr_a, idx_a;
  logic [2:0] addr_b, idx_b;
  logic [7:0] pc_a, pe_a, pc_b, pe_b, cen_a, cen_b;
  logic [7:0] cand_a = 8'd0, cand_b = 8'd0;
  logic [3:0] pr_a, pr_b, rad_a, rad_b;
  logic       en_a, en_b, run_a, run_b, done_a, done_b, to_a, to_b;
  logic       v_mdl_a = 1'b0, v_mdl_b = 1'b0, valid_a;
  logic [6:0] err_a, err_b;

  logic [7:0] rom_c [8];
  logic [3:0] rom_r [8];
  logic [7:0] rom_e [8];

  int total = 0;
  int bad   = 0;

  int         lat_a   = 3;
  bit         nov_a   = 1'b0;
  logic [7:0] wrong_a = 8'd0;
  int         cd_a    = 0;
  int         cd_b    = 0;

  logic [11:0] sb_q [$];
  int en_cnt_a = 0;
  int en_cnt_b = 0;

  assign valid_a = v_mdl_a | spur_a;

  set_seq_driver #(.N_PAT(4), .AW(2), .MAX_ERR(4), .TIMEOUT(16)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .pat_addr(addr_a),
    .pat_central(pc_a), .pat_radius(pr_a), .pat_expected(pe_a),
    .en(en_a), .central(cen_a), .radius(rad_a), .busy(busy_a),
    .valid(valid_a), .candidate(cand_a), .running(run_a), .done(done_a),
    .timeout(to_a), .err_cnt(err_a), .pat_idx(idx_a)
  );

  set_seq_driver #(.N_PAT(8), .AW(3), .MAX_ERR(2), .TIMEOUT(1024)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .pat_addr(addr_b),
    .pat_central(pc_b), .pat_radius(pr_b), .pat_expected(pe_b),
    .en(en_b), .central(cen_b), .radius(rad_b), .busy(1'b0),
    .valid(v_mdl_b), .candidate(cand_b), .running(run_b), .done(done_b),
    .timeout(to_b), .err_cnt(err_b), .pat_idx(idx_b)
  );

  function automatic logic [2:0] find_idx(input logic [7:0] c);
    find_idx = 3'd0;
    for (int i = 0; i < 8; i++)
      if (rom_c[i] == c) find_idx = 3'(i);
  endfunction

  // Synchronous pattern ROMs
  always @(posedge clk) begin
    pc_a <= rom_c[{1'b0, addr_a}];
    pr_a <= rom_r[{1'b0, addr_a}];
    pe_a <= rom_e[{1'b0, addr_a}];
    pc_b <= rom_c[addr_b];
    pr_b <= rom_r[addr_b];
    pe_b <= rom_e[addr_b];
  end

  // Behavioural SET A: valid lat_a cycles after en, optionally wrong per pattern
  always @(posedge clk) begin
    v_mdl_a <= 1'b0;
    if (en_a && !nov_a) begin
      cand_a <= rom_e[find_idx(cen_a)] + {7'd0, wrong_a[find_idx(cen_a)]};
      if (lat_a == 1) v_mdl_a <= 1'b1;
      else cd_a <= lat_a - 1;
    end else if (cd_a > 0) begin
      cd_a <= cd_a - 1;
      if (cd_a == 1) v_mdl_a <= 1'b1;
    end
  end

  // Behavioural SET B: L=3, always wrong
  always @(posedge clk) begin
    v_mdl_b <= 1'b0;
    if (en_b) begin
      cand_b <= rom_e[find_idx(cen_b)] + 8'd1;
      cd_b   <= 2;
    end else if (cd_b > 0) begin
      cd_b <= cd_b - 1;
      if (cd_b == 1) v_mdl_b <= 1'b1;
    end
  end

  task automatic mon_a();
    logic        prev = 1'b0;
    logic [11:0] exp_v;
    forever begin
      @(negedge clk);
      if (en_a) begin
        en_cnt_a++;
        total++;
        if (prev) begin
          bad++;
          $display("FAIL en_width_a: en high two cycles in a row, required one");
        end else if (sb_q.size() == 0) begin
          bad++;
          $display("FAIL sb_unexpected_en: got central=%0h radius=%0h, required no job", cen_a, rad_a);
        end else begin
          exp_v = sb_q.pop_front();
          if ({cen_a, rad_a} !== exp_v) begin
            bad++;
            $display("FAIL sb_job_operands: got %0h required %0h", {cen_a, rad_a}, exp_v);
          end
        end
      end
      prev = en_a;
    end
  endtask

  task automatic mon_b();
    forever begin
      @(negedge clk);
      if (en_b) begin
        total++;
        if (en_cnt_b < 8 && cen_b !== rom_c[en_cnt_b]) begin
          bad++;
          $display("FAIL job_central_b: got %0h required %0h", cen_b, rom_c[en_cnt_b]);
        end
        en_cnt_b++;
      end
    end
  endtask

  task automatic push_a(input int n);
    for (int i = 0; i < n; i++) sb_q.push_back({rom_c[i], rom_r[i]});
  endtask

  task automatic pulse_a();
    @(posedge clk); #1 start_a = 1'b1;
    @(posedge clk); #1 start_a = 1'b0;
  endtask

  task automatic wait_done_a(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (done_a) begin ok = 1'b1; break; end
    end
  endtask

  task automatic wait_en_a(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (en_a) begin ok = 1'b1; break; end
    end
  endtask

  task automatic check_end_a(input string nm, input bit ok, input int n_en, input int base,
                             input logic [6:0] e_err, input logic [1:0] e_idx);
    total++;
    if (!ok) begin bad++; $display("FAIL %s_wait: done never rose within bound", nm); end
    total++;
    if ({done_a, run_a, to_a, err_a, idx_a} !== {1'b1, 1'b0, 1'b0, e_err, e_idx}) begin
      bad++;
      $display("FAIL %s_status: got done=%b run=%b to=%b err=%0d idx=%0d required 1 0 0 %0d %0d",
               nm, done_a, run_a, to_a, err_a, idx_a, e_err, e_idx);
    end
    total++;
    if (en_cnt_a - base !== n_en || sb_q.size() != 0) begin
      bad++;
      $display("FAIL %s_jobs: got %0d en pulses (%0d left queued) required %0d",
               nm, en_cnt_a - base, sb_q.size(), n_en);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    total++;
    if ({addr_a, en_a, cen_a, rad_a, run_a, done_a, to_a, err_a, idx_a} !== '0) begin
      bad++;
      $display("FAIL reset_outputs: got en=%b run=%b done=%b err=%0d idx=%0d addr=%0d required all 0",
               en_a, run_a, done_a, err_a, idx_a, addr_a);
    end
    @(posedge clk); #1 rst = 1'b1;
  endtask

  task automatic test_clean();
    bit ok; int base;
    lat_a = 3; wrong_a = 8'd0; base = en_cnt_a;
    push_a(4); pulse_a(); wait_done_a(ok);
    check_end_a("clean", ok, 4, base, 7'd0, 2'd3);
  endtask

  task automatic test_mismatch();
    bit ok; int base;
    wrong_a = 8'b0000_0110; base = en_cnt_a;
    push_a(4); pulse_a(); wait_done_a(ok);
    check_end_a("mismatch", ok, 4, base, 7'd2, 2'd3);
    wrong_a = 8'd0;
  endtask

  task automatic test_busy_stall();
    bit ok; bit saw_en = 1'b0; int base;
    base = en_cnt_a; busy_a = 1'b1;
    push_a(4); pulse_a();
    repeat (20) begin @(negedge clk); if (en_a) saw_en = 1'b1; end
    total++;
    if (saw_en) begin bad++; $display("FAIL busy_stall: en rose while busy, required 0"); end
    @(posedge clk); #1 busy_a = 1'b0;
    @(negedge clk);
    total++;
    if (en_a !== 1'b0) begin bad++; $display("FAIL busy_release_early: got en=%b required 0", en_a); end
    @(negedge clk);
    total++;
    if (en_a !== 1'b1) begin bad++; $display("FAIL busy_release_issue: got en=%b required 1", en_a); end
    wait_done_a(ok);
    check_end_a("busy", ok, 4, base, 7'd0, 2'd3);
  endtask

  task automatic test_watchdog();
    bit ok; bit early = 1'b0;
    nov_a = 1'b1;
    push_a(1); pulse_a(); wait_en_a(ok);
    total++;
    if (!ok) begin bad++; $display("FAIL wd_en_wait: no en within bound"); end
    for (int n = 1; n < 16; n++) begin @(negedge clk); if (done_a) early = 1'b1; end
    @(negedge clk);
    total++;
    if (early) begin bad++; $display("FAIL wd_early: done rose before 16 cycles after en"); end
    total++;
    if ({done_a, to_a, run_a, err_a} !== {1'b1, 1'b1, 1'b0, 7'd0}) begin
      bad++;
      $display("FAIL wd_expiry: got done=%b timeout=%b run=%b err=%0d required 1 1 0 0",
               done_a, to_a, run_a, err_a);
    end
    nov_a = 1'b0;
  endtask

  task automatic test_reset_mid_run();
    bit ok; int k = 0; int base;
    lat_a = 3;
    push_a(4); pulse_a();
    for (int i = 0; i < 300 && k < 3; i++) begin @(negedge clk); if (en_a) k++; end
    @(negedge clk);
    #1 rst = 1'b0;
    #1;
    total++;
    if ({addr_a, en_a, cen_a, rad_a, run_a, done_a, to_a, err_a, idx_a} !== '0) begin
      bad++;
      $display("FAIL reset_mid_outputs: got run=%b idx=%0d addr=%0d cen=%0h required all 0",
               run_a, idx_a, addr_a, cen_a);
    end
    sb_q.delete();
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    base = en_cnt_a;
    push_a(4); pulse_a();
    @(negedge clk);
    total++;
    if ({addr_a, err_a, run_a} !== {2'd0, 7'd0, 1'b1}) begin
      bad++;
      $display("FAIL restart_state: got addr=%0d err=%0d run=%b required 0 0 1", addr_a, err_a, run_a);
    end
    wait_done_a(ok);
    check_end_a("restart", ok, 4, base, 7'd0, 2'd3);
  endtask

  task automatic test_ignored_strobes();
    bit ok; int base;
    lat_a = 6; base = en_cnt_a;
    push_a(4); pulse_a(); wait_en_a(ok);
    @(posedge clk); #1 start_a = 1'b1;
    @(posedge clk); #1 start_a = 1'b0;
    @(negedge clk);
    total++;
    if ({run_a, done_a, idx_a} !== {1'b1, 1'b0, 2'd0}) begin
      bad++;
      $display("FAIL start_ignored: got run=%b done=%b idx=%0d required 1 0 0", run_a, done_a, idx_a);
    end
    wait_done_a(ok);
    check_end_a("start_mid", ok, 4, base, 7'd0, 2'd3);

    lat_a = 3; base = en_cnt_a; busy_a = 1'b1;
    push_a(4); pulse_a();
    repeat (4) @(negedge clk);
    @(posedge clk); #1 spur_a = 1'b1;
    @(posedge clk); #1 spur_a = 1'b0;
    @(negedge clk);
    total++;
    if ({en_a, err_a, idx_a, run_a} !== {1'b0, 7'd0, 2'd0, 1'b1}) begin
      bad++;
      $display("FAIL spurious_valid: got en=%b err=%0d idx=%0d run=%b required 0 0 0 1",
               en_a, err_a, idx_a, run_a);
    end
    busy_a = 1'b0;
    wait_done_a(ok);
    check_end_a("spurious", ok, 4, base, 7'd0, 2'd3);
  endtask

  task automatic test_early_abort();
    bit ok = 1'b0; int base;
    base = en_cnt_b;
    @(posedge clk); #1 start_b = 1'b1;
    @(posedge clk); #1 start_b = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (done_b) begin ok = 1'b1; break; end
    end
    total++;
    if (!ok) begin bad++; $display("FAIL abort_wait: done never rose within bound"); end
    total++;
    if ({err_b, idx_b, to_b, run_b} !== {7'd2, 3'd1, 1'b0, 1'b0}) begin
      bad++;
      $display("FAIL abort_status: got err=%0d idx=%0d to=%b run=%b required 2 1 0 0",
               err_b, idx_b, to_b, run_b);
    end
    repeat (10) @(negedge clk);
    total++;
    if (en_cnt_b - base !== 2) begin
      bad++;
      $display("FAIL abort_jobs: got %0d en pulses required 2", en_cnt_b - base);
    end
  endtask

  initial begin
    for (int i = 0; i < 8; i++) begin
      rom_c[i] = 8'(17 * i + 3);
      rom_r[i] = 4'($urandom_range(0, 15));
      rom_e[i] = 8'($urandom_range(0, 255));
    end
    fork
      mon_a();
      mon_b();
    join_none
    test_reset();
    test_clean();
    test_mismatch();
    test_busy_stall();
    test_watchdog();
    test_reset_mid_run();
    test_ignored_strobes();
    test_early_abort();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: bench did not complete");
    $fatal(1);
  end

endmodule
`default_nettype wire
